// File: rtl/field_row_clear.sv
`default_nettype none
// ---------------------------------------------------------------------------
// field_row_clear: removes full rows from a 10x10 field and scores them.
// FIELD_VSYNC_PUBLISH_EN: publish oField on an iVS falling edge while idle.
// Revision: 1.0
// ---------------------------------------------------------------------------
module field_row_clear (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [0:99] iField,
  input  logic        iVS,
  output logic [0:99] oField,
  output logic [31:0] oScore,
  output logic        oBusy,
  output logic        oDone,
  output logic [3:0]  oRows
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST_ROW = 4'd9;

  logic [1:0]  state_q, state_d;
  logic [0:99] field_q, field_d;
  logic [0:99] ofield_q, ofield_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  rows_q, rows_d;
  logic [31:0] score_q, score_d;

  logic [6:0]  row_base;
  logic        row_full;
  logic [31:0] points;
  logic [32:0] score_sum;

`ifdef FIELD_VSYNC_PUBLISH_EN
  logic vs_q, vs_d;
  logic vs_fall;
  assign vs_d    = iVS;
  assign vs_fall = vs_q & ~iVS;
`else
  logic vs_unused;
  assign vs_unused = iVS;
`endif

  assign row_base = {3'b000, row_q} * 7'd10;
  assign row_full = &field_q[row_base +: 10];

  always_comb begin
    case (k_q)
      4'd0:    points = 32'd0;
      4'd1:    points = 32'd10;
      4'd2:    points = 32'd30;
      4'd3:    points = 32'd60;
      default: points = 32'd100;
    endcase
    score_sum = {1'b0, score_q} + {1'b0, points};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      field_q  <= '0;
      ofield_q <= '0;
      row_q    <= '0;
      k_q      <= '0;
      rows_q   <= '0;
      score_q  <= '0;
`ifdef FIELD_VSYNC_PUBLISH_EN
      vs_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      ofield_q <= ofield_d;
      row_q    <= row_d;
      k_q      <= k_d;
      rows_q   <= rows_d;
      score_q  <= score_d;
`ifdef FIELD_VSYNC_PUBLISH_EN
      vs_q     <= vs_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_SCAN;
      S_SCAN:  if (!row_full && (row_q == 4'd0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    field_d = field_q;
    row_d   = row_q;
    k_d     = k_q;
    rows_d  = rows_q;
    score_d = score_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          field_d = iField;
          row_d   = LAST_ROW;
          k_d     = 4'd0;
        end
      end
      S_SCAN: begin
        if (row_full) begin
          // Drop row r: every row above it moves down one, an empty row enters at the top.
          for (int j = 1; j < 10; j++) begin
            if (4'(j) <= row_q) field_d[10*j +: 10] = field_q[10*(j-1) +: 10];
          end
          field_d[0 +: 10] = '0;
          k_d = k_q + 4'd1;
        end else if (row_q != 4'd0) begin
          row_d = row_q - 4'd1;
        end else begin
          rows_d  = k_q;
          score_d = score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ofield_d = ofield_q;
`ifdef FIELD_VSYNC_PUBLISH_EN
    if (vs_fall && (state_q == S_IDLE)) ofield_d = field_q;
`else
    if (state_q == S_DONE) ofield_d = field_q;
`endif
  end

  always_comb begin
    oBusy  = (state_q != S_IDLE) && !iRST;
    oDone  = (state_q == S_DONE) && !iRST;
    oField = ofield_q;
    oScore = score_q;
    oRows  = rows_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_field_row_clear.sv
`default_nettype none
// Bench for field_row_clear: row-compaction reference model plus directed vectors.
module tb_field_row_clear;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iStart;
  logic [0:99] iField;
  logic        iVS;
  logic [0:99] oField;
  logic [31:0] oScore;
  logic        oBusy;
  logic        oDone;
  logic [3:0]  oRows;

  int checks = 0;
  int errors = 0;

  field_row_clear dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iStart (iStart),
    .iField (iField),
    .iVS    (iVS),
    .oField (oField),
    .oScore (oScore),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oRows  (oRows)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full rows vanish; the surviving rows keep their order and settle at the bottom.
  function automatic int clear_rows(input logic [0:99] f, output logic [0:99] res);
    int dst;
    int k;
    dst = 9;
    k   = 0;
    res = '0;
    for (int r = 9; r >= 0; r--) begin
      bit full;
      full = 1'b1;
      for (int c = 0; c < 10; c++) if (!f[10*r+c]) full = 1'b0;
      if (full) k++;
      else begin
        for (int c = 0; c < 10; c++) res[10*dst+c] = f[10*r+c];
        dst--;
      end
    end
    return k;
  endfunction

  function automatic logic [31:0] add_points(input logic [31:0] s, input int k);
    longint t;
    int p;
    p = (k == 0) ? 0 : (k == 1) ? 10 : (k == 2) ? 30 : (k == 3) ? 60 : 100;
    t = longint'(s) + longint'(p);
    if (t > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return t[31:0];
  endfunction

  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_vs_prev;
  int          m_cnt, m_k;
  logic [0:99] m_result, m_work, m_ofield;
  logic [31:0] m_score;
  logic [3:0]  m_rows;

  always @(posedge iCLK) begin
    if (iRST) begin
      m_valid   = 1'b1;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_cnt     = 0;
      m_k       = 0;
      m_result  = '0;
      m_work    = '0;
      m_ofield  = '0;
      m_score   = '0;
      m_rows    = '0;
      m_vs_prev = 1'b1;
    end else begin
`ifdef FIELD_VSYNC_PUBLISH_EN
      if (m_vs_prev && !iVS && !m_busy) m_ofield = m_work;
`endif
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
`ifndef FIELD_VSYNC_PUBLISH_EN
        m_ofield = m_result;
`endif
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done  = 1'b1;
          m_rows  = 4'(m_k);
          m_score = add_points(m_score, m_k);
        end
      end else if (iStart) begin
        m_k    = clear_rows(iField, m_result);
        m_work = m_result;
        m_cnt  = 10 + m_k;
        m_busy = 1'b1;
      end
      m_vs_prev = iVS;
    end
  end

  always @(negedge iCLK) begin
    if (m_valid) begin
      chk("busy",  128'(oBusy),  128'(m_busy && !iRST));
      chk("done",  128'(oDone),  128'(m_done && !iRST));
      chk("rows",  128'(oRows),  128'(m_rows));
      chk("score", 128'(oScore), 128'(m_score));
      chk("field", 128'(oField), 128'(m_ofield));
    end
  end

  initial begin
    iVS = 1'b1;
    forever begin
      repeat (11) @(posedge iCLK);
      #1 iVS = 1'b0;
      repeat (2) @(posedge iCLK);
      #1 iVS = 1'b1;
    end
  end

  task automatic run_op(input logic [0:99] f, output int lat);
    @(posedge iCLK);
    #1 iField = f; iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0; iField = ~f;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (oDone) break;
      @(posedge iCLK);
      lat++;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge iCLK);
    #1 iRST = 1'b1; iStart = 1'b0;
    repeat (n) @(posedge iCLK);
    #1 iRST = 1'b0;
  endtask

  int          lat;
  int          ndone;
  logic [0:99] f;
  logic [0:99] exp_f;

  initial begin
    iRST = 1'b1; iStart = 1'b0; iField = '0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_busy",  128'(oBusy),  128'(0));
    chk("rst_done",  128'(oDone),  128'(0));
    chk("rst_score", 128'(oScore), 128'(0));
    chk("rst_rows",  128'(oRows),  128'(0));
    chk("rst_field", 128'(oField), 128'(0));
    @(posedge iCLK);
    #1 iRST = 1'b0;

    f = '0;
    run_op(f, lat);
    chk("empty_lat",   128'(lat),    128'(10));
    chk("empty_rows",  128'(oRows),  128'(0));
    chk("empty_score", 128'(oScore), 128'(0));

    f = '0;
    for (int c = 0; c < 10; c++) f[90+c] = 1'b1;
    f[80] = 1'b1;
    run_op(f, lat);
    chk("r9_lat",   128'(lat),    128'(11));
    chk("r9_rows",  128'(oRows),  128'(1));
    chk("r9_score", 128'(oScore), 128'(10));
`ifndef FIELD_VSYNC_PUBLISH_EN
    chk("r9_field_hold", 128'(oField), 128'(0));
    @(posedge iCLK);
    @(negedge iCLK);
    exp_f = '0;
    exp_f[90] = 1'b1;
    chk("r9_field", 128'(oField), 128'(exp_f));
`endif

    do_reset(2);
    f = '0;
    for (int i = 80; i < 100; i++) f[i] = 1'b1;
    run_op(f, lat);
    chk("two_lat",   128'(lat),    128'(12));
    chk("two_score", 128'(oScore), 128'(30));

    f = '0;
    for (int i = 60; i < 100; i++) f[i] = 1'b1;
    run_op(f, lat);
    chk("four_lat",   128'(lat),    128'(14));
    chk("four_rows",  128'(oRows),  128'(4));
    chk("four_score", 128'(oScore), 128'(130));
`ifndef FIELD_VSYNC_PUBLISH_EN
    @(posedge iCLK);
    @(negedge iCLK);
    chk("four_field", 128'(oField), 128'(0));
`endif

    f = '1;
    run_op(f, lat);
    chk("full_lat",   128'(lat),    128'(20));
    chk("full_rows",  128'(oRows),  128'(10));
    chk("full_score", 128'(oScore), 128'(230));

    // Reset three cycles into a scan, with iStart held high through the reset edge.
    f = '0;
    for (int c = 0; c < 10; c++) f[90+c] = 1'b1;
    @(posedge iCLK);
    #1 iField = f; iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b1; iStart = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    chk("midrst_busy",  128'(oBusy),  128'(0));
    chk("midrst_done",  128'(oDone),  128'(0));
    chk("midrst_score", 128'(oScore), 128'(0));
    chk("midrst_rows",  128'(oRows),  128'(0));
    chk("midrst_field", 128'(oField), 128'(0));
    @(posedge iCLK);
    #1 iRST = 1'b0; iStart = 1'b0;

    // A second start pulse mid-scan must not queue another operation.
    @(posedge iCLK);
    #1 iField = f; iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iStart = 1'b1;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (oDone) ndone++;
    end
    chk("single_done",  128'(ndone),  128'(1));
    chk("single_score", 128'(oScore), 128'(10));
    chk("single_busy",  128'(oBusy),  128'(0));

    repeat (2) @(posedge iCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/field_row_clear.md
FIELD_ROW_CLEAR -- requirements
Module: field_row_clear

Interface
REQ-001 SHALL have port iCLK, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port iRST, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port iStart, input, 1: one-cycle pulse from game logic when a piece has locked.
REQ-004 SHALL have port iField, input, [0:99]: the game field; bit 10*r+c is row r (0 = top), column c (0 = left); 1 = occupied.
REQ-005 SHALL have port iVS, input, 1: active-low vertical sync from the video sync generator.
REQ-006 SHALL have port oField, output, [0:99]: display field, same bit layout as iField, feeding the VGA controller.
REQ-007 SHALL have port oScore, output, [31:0]: accumulated score.
REQ-008 SHALL have port oBusy, output, 1: high while the engine is not in IDLE.
REQ-009 SHALL have port oDone, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port oRows, output, [3:0]: rows cleared by the most recent operation.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, SCAN and DONE.
REQ-012 IDLE: on iStart=1, SHALL load iField into the working register, set row index r=9 and count k=0, and go to SCAN.
REQ-013 SCAN, row r full (all 10 bits set): at the next edge SHALL copy each row j (1..r) from row j-1, clear row 0, increment k, and keep r.
REQ-014 SCAN, row r not full and r>0: SHALL decrement r.
REQ-015 SCAN, row r not full and r=0: SHALL go to DONE.
REQ-016 Latency: oDone SHALL be high exactly during the cycle that follows 10+k edges after the edge that sampled iStart.
REQ-017 DONE: SHALL assert oDone, load oRows=k, add to oScore per 0→0, 1→10, 2→30, 3→60, ≥4→100 (saturating at 32'hFFFF_FFFF), and return to IDLE.
REQ-018 oBusy SHALL be high in SCAN and DONE.
REQ-019 SHALL ignore iStart in SCAN and DONE; no queuing.
REQ-020 iField SHALL be sampled only on the loading edge; later changes to iField SHALL NOT affect the operation in progress.
REQ-021 k SHALL NOT exceed 10; the FSM always terminates, because each shift inserts an empty top row.
REQ-022 SHALL register the previous iVS to detect its falling edge (1→0).

Reset
REQ-023 iRST=1 at an edge SHALL force IDLE, and clear the working field, oField, oScore, oRows, r and k.
REQ-024 During reset, oBusy and oDone SHALL be 0.
REQ-025 Reset SHALL take priority over every other event, including mid-SCAN and a coincident iStart.
REQ-026 The first operation after reset release SHALL behave as from power-up.

Configuration
REQ-027 Macro FIELD_VSYNC_PUBLISH_EN defined: oField SHALL take the working field only on an edge where an iVS falling edge is detected and the FSM is in IDLE. An iVS falling edge while busy SHALL be skipped, and oField SHALL hold until the next qualifying falling edge.
REQ-028 Macro not defined: oField SHALL take the working field on the edge leaving DONE, and iVS SHALL be unused.

Verification
REQ-029 Empty field, iStart → oDone 10 cycles after the start edge, oRows=0, oScore=0.
REQ-030 Row 9 full, row 8 = bit 80 only, iStart → oDone at 11 cycles, oRows=1, oScore=10, row 9 = bit 90 only, rows 0..8 empty.
REQ-031 Rows 6..9 full, oScore preloaded by an earlier operation to 30 → oDone at 14 cycles, oRows=4, oScore=130, field empty; then all 100 bits set → oRows=10, oDone at 20 cycles, oScore=230.
REQ-032 With FIELD_VSYNC_PUBLISH_EN: iVS falls during SCAN → oField unchanged; next iVS fall in IDLE → oField equals the cleared field on that edge. Without the macro: oField updates on the edge after oDone.
REQ-033 iRST asserted 3 cycles into SCAN with iStart held high → next cycle IDLE, all outputs 0; a second iStart pulse during SCAN of a later operation is ignored (single oDone).
